// File: rtl/fddi_claim_resp.sv
// FDDI claim responder: qualifies a claim for HOLD_CYCLES, then grants for
// GRANT_CYCLES or yields for as long as the claim stays up. A ring drop
// aborts any transaction. grant_cnt_o counts grants and saturates.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a fresh claim rise while the ring is active
// WAIT  | claim hold qualification, timer counting down
// GRANT | grant pulse active, timer counting down the pulse length
// YIELD | yielding to the claim until the claim drops
module fddi_claim_resp #(
    parameter int HOLD_CYCLES  = 4,
    parameter int GRANT_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             claim_i,
    input  logic             merge_i,
    input  logic             fddi_i,
    output logic             grant_o,
    output logic             yield_o,
    output logic             busy_o,
    output logic             abort_o,
    output logic [CNT_W-1:0] grant_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2,
        YIELD = 2'd3
    } state_t;

    localparam logic [7:0]       HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]       GRANT_LOAD = 8'(GRANT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             claim_q;
    logic             rise;

    // claim_q clears in reset so a claim held through release reads as a rise
    assign rise = claim_i & ~claim_q;

    // State, timer, counter and edge-detect registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
            claim_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
            claim_q <= claim_i;
        end
    end

    // Next-state logic; merge only matters on the WAIT terminal-count edge
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        abort_d = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rise && fddi_i) begin
                    state_d = WAIT;
                    timer_d = HOLD_LOAD;
                end
            end
            WAIT: begin
                if (!fddi_i) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (!claim_i) begin
                    state_d = IDLE;
                end else if (timer_q == 8'd0) begin
                    if (merge_i) begin
                        state_d = GRANT;
                        timer_d = GRANT_LOAD;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = YIELD;
                    end
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            GRANT: begin
                if (!fddi_i) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (timer_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            YIELD: begin
                if (!fddi_i) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (!claim_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_o     = (state_q == GRANT);
    assign yield_o     = (state_q == YIELD);
    assign busy_o      = (state_q != IDLE);
    assign abort_o     = abort_q;
    assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_fddi_claim_resp.sv
// Bench for fddi_claim_resp: a vector table on the default configuration
// plus a hand-written saturation sequence on a narrow-counter instance.
module tb_fddi_claim_resp;

    logic       clk = 1'b0;
    logic       rst, claim, merge, fddi;
    logic       grant, yield_s, busy, abort;
    logic [7:0] cnt;

    logic       rst2, claim2, merge2, fddi2;
    logic       grant2, yield2, busy2, abort2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fddi_claim_resp #(.HOLD_CYCLES(4), .GRANT_CYCLES(2), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .claim_i(claim), .merge_i(merge), .fddi_i(fddi),
        .grant_o(grant), .yield_o(yield_s), .busy_o(busy), .abort_o(abort),
        .grant_cnt_o(cnt)
    );

    fddi_claim_resp #(.HOLD_CYCLES(1), .GRANT_CYCLES(1), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst2), .claim_i(claim2), .merge_i(merge2), .fddi_i(fddi2),
        .grant_o(grant2), .yield_o(yield2), .busy_o(busy2), .abort_o(abort2),
        .grant_cnt_o(cnt2)
    );

    typedef struct {
        logic       rst, claim, merge, fddi;
        logic       grant, yield_e, busy, abort;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, c, m, f, g, y, b, a, input logic [7:0] n);
        vec_t v;
        v.rst = r; v.claim = c; v.merge = m; v.fddi = f;
        v.grant = g; v.yield_e = y; v.busy = b; v.abort = a; v.cnt = n;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int exp_cnt2[5];
        logic [11:0] act_p, exp_p;
        exp_cnt2 = '{1, 2, 3, 3, 3};

        rst = 1'b1; claim = 1'b0; merge = 1'b1; fddi = 1'b1;
        rst2 = 1'b1; claim2 = 1'b0; merge2 = 1'b1; fddi2 = 1'b1;

        //     rst clm mrg fdi  gnt yld bsy abt cnt
        // reset, then grant path with merge wiggling inside WAIT
        add(1, 0, 1, 1,  0, 0, 0, 0, 0);
        add(0, 1, 1, 1,  0, 0, 1, 0, 0);
        add(0, 1, 0, 1,  0, 0, 1, 0, 0);
        add(0, 1, 0, 1,  0, 0, 1, 0, 0);
        add(0, 1, 0, 1,  0, 0, 1, 0, 0);
        add(0, 1, 1, 1,  1, 0, 1, 0, 1);
        add(0, 1, 0, 1,  1, 0, 1, 0, 1);
        add(0, 1, 1, 1,  0, 0, 0, 0, 1);
        add(0, 1, 1, 1,  0, 0, 0, 0, 1);
        add(0, 0, 1, 1,  0, 0, 0, 0, 1);
        // reset, then yield path: claim high 10 cycles
        add(1, 0, 1, 1,  0, 0, 0, 0, 0);
        add(0, 1, 0, 1,  0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1,  0, 0, 1, 0, 0);
        add(0, 1, 0, 1,  0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 1,  0, 1, 1, 0, 0);
        add(0, 0, 1, 1,  0, 0, 0, 0, 0);
        // short claim: 3 cycles busy, no abort
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1,  0, 0, 1, 0, 0);
        add(0, 0, 1, 1,  0, 0, 0, 0, 0);
        // rise with ring down is ignored, held claim does not retrigger
        add(0, 1, 1, 0,  0, 0, 0, 0, 0);
        add(0, 1, 1, 1,  0, 0, 0, 0, 0);
        add(0, 0, 1, 1,  0, 0, 0, 0, 0);
        // ring drop mid-GRANT
        for (int i = 0; i < 4; i++) add(0, 1, 1, 1,  0, 0, 1, 0, 0);
        add(0, 1, 1, 1,  1, 0, 1, 0, 1);
        add(0, 1, 1, 0,  0, 0, 0, 1, 1);
        add(0, 1, 1, 1,  0, 0, 0, 0, 1);
        add(0, 0, 1, 1,  0, 0, 0, 0, 1);
        // ring drop mid-WAIT
        add(0, 1, 1, 1,  0, 0, 1, 0, 1);
        add(0, 1, 1, 0,  0, 0, 0, 1, 1);
        add(0, 0, 1, 1,  0, 0, 0, 0, 1);
        // ring drop mid-YIELD
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1,  0, 0, 1, 0, 1);
        add(0, 1, 0, 1,  0, 1, 1, 0, 1);
        add(0, 1, 0, 0,  0, 0, 0, 1, 1);
        add(0, 0, 0, 1,  0, 0, 0, 0, 1);
        // reset mid-WAIT with claim held: first post-reset edge re-enters WAIT
        add(0, 1, 1, 1,  0, 0, 1, 0, 1);
        add(0, 1, 1, 1,  0, 0, 1, 0, 1);
        add(1, 1, 1, 1,  0, 0, 0, 0, 0);
        add(0, 1, 1, 1,  0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1,  0, 0, 1, 0, 0);
        add(0, 1, 1, 1,  1, 0, 1, 0, 1);
        // reset mid-GRANT
        add(1, 1, 1, 1,  0, 0, 0, 0, 0);
        add(0, 0, 1, 1,  0, 0, 0, 0, 0);
        // reset mid-YIELD
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1,  0, 0, 1, 0, 0);
        add(0, 1, 0, 1,  0, 1, 1, 0, 0);
        add(1, 0, 0, 1,  0, 0, 0, 0, 0);
        // ring drop and claim drop together: abort wins
        add(0, 1, 1, 1,  0, 0, 1, 0, 0);
        add(0, 0, 1, 0,  0, 0, 0, 1, 0);
        add(0, 0, 1, 1,  0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; claim = vecs[i].claim;
            merge = vecs[i].merge; fddi = vecs[i].fddi;
            step();
            act_p = {grant, yield_s, busy, abort, cnt};
            exp_p = {vecs[i].grant, vecs[i].yield_e, vecs[i].busy, vecs[i].abort, vecs[i].cnt};
            checks++;
            if (act_p !== exp_p) begin
                errors++;
                $display("FAIL vec%0d: got g=%b y=%b b=%b a=%b cnt=%0d expected g=%b y=%b b=%b a=%b cnt=%0d",
                         i, grant, yield_s, busy, abort, cnt,
                         vecs[i].grant, vecs[i].yield_e, vecs[i].busy, vecs[i].abort, vecs[i].cnt);
            end
        end

        // narrow counter: five complete grants saturate at 3
        rst2 = 1'b1;
        step();
        check("d2_reset_cnt", int'(cnt2), 0);
        check("d2_reset_busy", int'(busy2), 0);
        rst2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            claim2 = 1'b1;
            step();
            check("d2_wait_busy", int'({busy2, grant2}), 2);
            step();
            check("d2_grant", int'(grant2), 1);
            check("d2_cnt", int'(cnt2), exp_cnt2[k]);
            claim2 = 1'b0;
            step();
            check("d2_grant_len", int'({grant2, busy2, abort2}), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
